// File: rtl/cp0_int_timer_ctrl.sv
// CP0 interrupt/timer unit: owns Count/Compare/IP[7:0], synchronises and
// latches hardware interrupt lines, and produces the masked request and
// highest-priority pending vector.
module cp0_int_timer_ctrl #(
    parameter int unsigned NUM_HW_INT  = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COUNT_DIV   = 2,
    parameter int unsigned TIMER_LINE  = 5,
    parameter int unsigned EDGE_MASK   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic [NUM_HW_INT-1:0] int_clr,
    input  logic [1:0]            sw_ip,
    input  logic                  status_ie,
    input  logic                  status_exl,
    input  logic                  status_erl,
    input  logic [7:0]            status_im,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic                  ti_o,
    output logic [7:0]            ip_o,
    output logic                  int_req,
    output logic [2:0]            int_vec
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);
    localparam logic [NUM_HW_INT-1:0] EDGE_LINES = NUM_HW_INT'(EDGE_MASK);
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;

    logic [PW-1:0]         presc_q;
    logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
    logic [NUM_HW_INT-1:0] synced_d_q;
    logic [NUM_HW_INT-1:0] pending_q;

    logic                  wr_ok;
    logic                  count_wr;
    logic                  compare_wr;
    logic                  tick;
    logic [31:0]           count_inc;
    logic [NUM_HW_INT-1:0] synced;
    logic [NUM_HW_INT-1:0] rise;
    logic [7:0]            masked;

    assign wr_ok      = we & ~stall;
    assign count_wr   = wr_ok & (waddr == REG_COUNT);
    assign compare_wr = wr_ok & (waddr == REG_COMPARE);
    assign tick       = (presc_q == PRESC_LAST);
    assign count_inc  = count_o + 32'd1;
    assign synced     = sync_q[SYNC_STAGES-1];
    assign rise       = synced & ~synced_d_q;

    // Prescaled Count, Compare and sticky timer interrupt; mtc0 writes win over tick/match.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            count_o   <= '0;
            compare_o <= '0;
            ti_o      <= 1'b0;
        end else begin
            if (count_wr) begin
                count_o <= wdata;
                presc_q <= '0;
            end else begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    count_o <= count_inc;
                end
            end
            if (compare_wr) begin
                compare_o <= wdata;
                ti_o      <= 1'b0;
            end else if (tick && !count_wr && (count_inc == compare_o)) begin
                ti_o <= 1'b1;
            end
        end
    end

    // Input synchroniser chain and per-line level/edge pending stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
            synced_d_q <= '0;
            pending_q  <= '0;
        end else begin
            sync_q[0] <= int_i;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            synced_d_q <= synced;
            pending_q  <= (~EDGE_LINES & synced)
                        | (EDGE_LINES & (rise | (pending_q & ~int_clr)));
        end
    end

    // Cause.IP view: software bits, hardware pending lines, timer folded into its line.
    always_comb begin
        ip_o      = '0;
        ip_o[1:0] = sw_ip;
        for (int i = 0; i < int'(NUM_HW_INT); i++) begin
            ip_o[2+i] = pending_q[i];
        end
        ip_o[2+TIMER_LINE] = ip_o[2+TIMER_LINE] | ti_o;
    end

    assign masked  = ip_o & status_im;
    assign int_req = status_ie & ~status_exl & ~status_erl & (|masked);

    // Priority encoder: highest masked IP bit wins.
    always_comb begin
        int_vec = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (masked[i]) begin
                int_vec = 3'(i);
            end
        end
    end

endmodule

// File: tb/tb_cp0_int_timer_ctrl.sv
// Self-checking bench for cp0_int_timer_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_cp0_int_timer_ctrl;

    localparam int NHW = 6;
    localparam int SS  = 2;
    localparam int DIV = 2;
    localparam int TL  = 5;
    localparam logic [NHW-1:0] EM = 6'b001010;

    logic            clk;
    logic            rst;
    logic            stall;
    logic            we;
    logic [4:0]      waddr;
    logic [31:0]     wdata;
    logic [NHW-1:0]  int_i;
    logic [NHW-1:0]  int_clr;
    logic [1:0]      sw_ip;
    logic            status_ie;
    logic            status_exl;
    logic            status_erl;
    logic [7:0]      status_im;
    logic [31:0]     count_o;
    logic [31:0]     compare_o;
    logic            ti_o;
    logic [7:0]      ip_o;
    logic            int_req;
    logic [2:0]      int_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0]     m_count;
    logic [31:0]     m_compare;
    logic            m_ti;
    int              m_phase;
    logic [NHW-1:0]  m_pend;
    logic [NHW-1:0]  hist [8];

    cp0_int_timer_ctrl #(
        .NUM_HW_INT (NHW),
        .SYNC_STAGES(SS),
        .COUNT_DIV  (DIV),
        .TIMER_LINE (TL),
        .EDGE_MASK  (32'(EM))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .int_i     (int_i),
        .int_clr   (int_clr),
        .sw_ip     (sw_ip),
        .status_ie (status_ie),
        .status_exl(status_exl),
        .status_erl(status_erl),
        .status_im (status_im),
        .count_o   (count_o),
        .compare_o (compare_o),
        .ti_o      (ti_o),
        .ip_o      (ip_o),
        .int_req   (int_req),
        .int_vec   (int_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_ip();
        logic [7:0] ip;
        ip = {2'b00, m_pend, sw_ip};
        if (m_ti) ip[2+TL] = 1'b1;
        return ip;
    endfunction

    function automatic logic model_req();
        return status_ie && !status_exl && !status_erl && ((model_ip() & status_im) != 8'h00);
    endfunction

    function automatic logic [2:0] model_vec();
        logic [7:0] m;
        m = model_ip() & status_im;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_step();
        logic            cw;
        logic            pw;
        logic            tk;
        logic [NHW-1:0]  sy;
        logic [NHW-1:0]  pv;
        if (rst) begin
            m_count = 0; m_compare = 0; m_ti = 0; m_phase = 0; m_pend = 0;
            for (int k = 0; k < 8; k++) hist[k] = '0;
        end else begin
            cw = we && !stall && (waddr == 5'd9);
            pw = we && !stall && (waddr == 5'd11);
            tk = (m_phase == DIV - 1);
            sy = hist[SS-1];
            pv = hist[SS];
            for (int i = 0; i < NHW; i++) begin
                if (EM[i]) m_pend[i] = (sy[i] && !pv[i]) || (m_pend[i] && !int_clr[i]);
                else       m_pend[i] = sy[i];
            end
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = int_i;
            if (pw) m_ti = 0;
            else if (tk && !cw && (m_count + 32'd1 == m_compare)) m_ti = 1;
            if (pw) m_compare = wdata;
            if (cw) begin
                m_count = wdata;
                m_phase = 0;
            end else begin
                if (tk) m_count = m_count + 32'd1;
                m_phase = (m_phase + 1) % DIV;
            end
        end
    endtask

    task automatic compare_all();
        check("count",   count_o,          m_count);
        check("compare", compare_o,        m_compare);
        check("ti",      32'(ti_o),        32'(m_ti));
        check("ip",      32'(ip_o),        32'(model_ip()));
        check("int_req", 32'(int_req),     32'(model_req()));
        check("int_vec", 32'(int_vec),     32'(model_vec()));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1; stall = 0; we = 0; waddr = 0; wdata = 0;
        int_i = 0; int_clr = 0; sw_ip = 0;
        status_ie = 0; status_exl = 0; status_erl = 0; status_im = 0;
        m_count = 0; m_compare = 0; m_ti = 0; m_phase = 0; m_pend = 0;
        for (int k = 0; k < 8; k++) hist[k] = '0;

        // Reset and prescaled counting
        cycle(); cycle();
        check("rst_count", count_o, 0);
        check("rst_ip", 32'(ip_o), 0);
        check("rst_req", 32'(int_req), 0);
        check("rst_vec", 32'(int_vec), 0);
        rst = 0;
        repeat (10) cycle();
        check("t1_count5", count_o, 5);

        // Compare match raises TI; Compare write clears it
        status_ie = 1; status_im = 8'h80;
        we = 1; waddr = 5'd11; wdata = 32'd8;
        cycle();
        we = 0;
        for (int k = 0; k < 40 && count_o != 32'd8; k++) cycle();
        check("t2_reach8", count_o, 8);
        check("t2_ti", 32'(ti_o), 1);
        check("t2_ip7", 32'(ip_o[7]), 1);
        check("t2_req", 32'(int_req), 1);
        cycle();
        check("t2_ti_sticky", 32'(ti_o), 1);
        we = 1; waddr = 5'd11; wdata = 32'h1000;
        cycle();
        we = 0;
        check("t2_ti_clr", 32'(ti_o), 0);

        // Level line 0 latency, both edges
        status_im = 8'h00;
        int_i = 6'b000001;
        cycle(); cycle();
        check("t3_rise_early", 32'(ip_o[2]), 0);
        cycle();
        check("t3_rise", 32'(ip_o[2]), 1);
        int_i = 6'b000000;
        cycle(); cycle();
        check("t3_fall_early", 32'(ip_o[2]), 1);
        cycle();
        check("t3_fall", 32'(ip_o[2]), 0);

        // Edge line 1: latch, clear, then set winning over clear
        int_i = 6'b000010; cycle(); int_i = 0;
        repeat (4) cycle();
        check("t4_latched", 32'(ip_o[3]), 1);
        int_clr = 6'b000010; cycle(); int_clr = 0;
        check("t4_cleared", 32'(ip_o[3]), 0);
        int_i = 6'b000010; cycle(); int_i = 0;
        repeat (4) cycle();
        check("t4_relatched", 32'(ip_o[3]), 1);
        int_i = 6'b000010; cycle(); int_i = 0;
        cycle();
        int_clr = 6'b000010; cycle(); int_clr = 0;
        check("t4_set_wins", 32'(ip_o[3]), 1);
        int_clr = 6'b000010; cycle(); int_clr = 0;

        // Priority vector and EXL masking
        int_i = 6'b001001; cycle(); int_i = 6'b000001;
        repeat (4) cycle();
        status_im = 8'hFF; status_ie = 1;
        cycle();
        check("t5_vec", 32'(int_vec), 5);
        check("t5_req", 32'(int_req), 1);
        check("t5_ip", 32'(ip_o), 32'h24);
        status_exl = 1;
        cycle();
        check("t5_exl_req", 32'(int_req), 0);
        check("t5_exl_vec", 32'(int_vec), 5);
        status_exl = 0; int_i = 0;
        int_clr = 6'b001000; cycle(); int_clr = 0;

        // Stalled write dropped, then Count wrap onto Compare=0
        we = 1; waddr = 5'd11; wdata = 32'd0; cycle();
        stall = 1; waddr = 5'd9; wdata = 32'hFFFF_FFFE; cycle();
        check("t6_stall_drop", 32'(count_o == 32'hFFFF_FFFE), 0);
        stall = 0; cycle(); we = 0;
        check("t6_load", count_o, 32'hFFFF_FFFE);
        check("t6_load_no_ti", 32'(ti_o), 0);
        repeat (2) cycle();
        check("t6_ffff", count_o, 32'hFFFF_FFFF);
        repeat (2) cycle();
        check("t6_wrap", count_o, 0);
        check("t6_wrap_ti", 32'(ti_o), 1);

        // Randomized traffic including occasional mid-run reset
        for (int n = 0; n < 1500; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 3) == 0);
            we    = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 2))
                0:       waddr = 5'd9;
                1:       waddr = 5'd11;
                default: waddr = 5'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       wdata = 32'($urandom_range(0, 40));
                1:       wdata = m_count + 32'($urandom_range(0, 6));
                2:       wdata = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: wdata = $urandom;
            endcase
            int_i      = int_i ^ (6'($urandom) & 6'($urandom));
            int_clr    = 6'($urandom) & 6'($urandom) & 6'($urandom);
            sw_ip      = 2'($urandom);
            status_ie  = ($urandom_range(0, 3) != 0);
            status_exl = ($urandom_range(0, 5) == 0);
            status_erl = ($urandom_range(0, 7) == 0);
            status_im  = 8'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
